mem_store_ctrl: RTL and testbench

MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

---
 rtl/mem_store_ctrl_if.sv | 24 ++
 rtl/mem_store_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_store_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_ctrl_if.sv
// Store-side data bus bundle between the store controller and memory.
// master: controller drives request fields; slave: memory answers with addr_ok/data_ok.
interface mem_store_ctrl_if;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [3:0]  data_wstrb_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;

    modport master (
        output data_req_o, data_wr_o, data_size_o,
        output data_addr_o, data_wdata_o, data_wstrb_o,
        input  data_addr_ok_i, data_data_ok_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_size_o,
        input  data_addr_o, data_wdata_o, data_wstrb_o,
        output data_addr_ok_i, data_data_ok_i
    );
endinterface

// File: rtl/mem_store_ctrl.sv
// Store controller: SB/SH/SW/SWL/SWR/SC lane formatting, bus handshake, LL bit.
// Ports: clk/rst, op inputs (valid_i, store_op_i, mem_addr_i, reg2_i), ll/flush
// controls, bus (master modport), stall_o/done_o/sc_result_o, ades_o/badvaddr_o, llbit_o.
module mem_store_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [2:0]             store_op_i,
    input  logic [31:0]            mem_addr_i,
    input  logic [31:0]            reg2_i,
    input  logic                   ll_i,
    input  logic                   clr_llbit_i,
    input  logic                   flush_i,
    mem_store_ctrl_if.master       bus,
    output logic                   stall_o,
    output logic                   done_o,
    output logic                   sc_result_o,
    output logic                   ades_o,
    output logic [31:0]            badvaddr_o,
    output logic                   llbit_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t      state_q;
    logic [1:0]  size_q,  size_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        sc_q;
    logic        llbit_q, llbit_d;

    logic is_sb, is_sh, is_sw, is_swl, is_swr, is_sc;
    logic op_ok, mis, accept, sc_fail, start, bus_done;
    logic aok, dok;

    assign aok = bus.data_addr_ok_i;
    assign dok = bus.data_data_ok_i;

    assign is_sb  = store_op_i == 3'd1;
    assign is_sh  = store_op_i == 3'd2;
    assign is_sw  = store_op_i == 3'd3;
    assign is_swl = store_op_i == 3'd4;
    assign is_swr = store_op_i == 3'd5;
    assign is_sc  = store_op_i == 3'd6;

    assign op_ok = valid_i && !flush_i && !rst && (state_q == IDLE) &&
                   (is_sb || is_sh || is_sw || is_swl || is_swr || is_sc);
    assign mis   = (is_sh && mem_addr_i[0]) ||
                   ((is_sw || is_sc) && (mem_addr_i[1:0] != 2'b00));

    assign accept  = op_ok && !mis;
    // SC without a live link never touches the bus; it fails on the spot.
    assign sc_fail = accept && is_sc && !llbit_q;
    assign start   = accept && !sc_fail;

    assign bus_done = !rst &&
                      (((state_q == REQ) && aok && dok) ||
                       ((state_q == WAIT) && dok));

    always_comb begin
        size_d  = 2'd0;
        addr_d  = mem_addr_i;
        wstrb_d = 4'b0000;
        wdata_d = 32'h0;
        unique case (1'b1)
            is_sb: begin
                wstrb_d = 4'b0001 << mem_addr_i[1:0];
                wdata_d = {4{reg2_i[7:0]}};
            end
            is_sh: begin
                size_d  = 2'd1;
                wstrb_d = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{reg2_i[15:0]}};
            end
            is_sw, is_sc: begin
                size_d  = 2'd2;
                wstrb_d = 4'b1111;
                wdata_d = reg2_i;
            end
            is_swl: begin
                size_d = 2'd2;
                addr_d = {mem_addr_i[31:2], 2'b00};
                case (mem_addr_i[1:0])
                    2'b00: begin wstrb_d = 4'b0001; wdata_d = {24'h0, reg2_i[31:24]}; end
                    2'b01: begin wstrb_d = 4'b0011; wdata_d = {16'h0, reg2_i[31:16]}; end
                    2'b10: begin wstrb_d = 4'b0111; wdata_d = {8'h0, reg2_i[31:8]}; end
                    default: begin wstrb_d = 4'b1111; wdata_d = reg2_i; end
                endcase
            end
            is_swr: begin
                size_d = 2'd2;
                addr_d = {mem_addr_i[31:2], 2'b00};
                case (mem_addr_i[1:0])
                    2'b00: begin wstrb_d = 4'b1111; wdata_d = reg2_i; end
                    2'b01: begin wstrb_d = 4'b1110; wdata_d = {reg2_i[23:0], 8'h0}; end
                    2'b10: begin wstrb_d = 4'b1100; wdata_d = {reg2_i[15:0], 16'h0}; end
                    default: begin wstrb_d = 4'b1000; wdata_d = {reg2_i[7:0], 24'h0}; end
                endcase
            end
            default: ;
        endcase
    end

    // Clear beats set: an exception in the LL cycle must not leave a stale link.
    always_comb begin
        llbit_d = llbit_q;
        if (ll_i)
            llbit_d = 1'b1;
        if (clr_llbit_i || (bus_done && sc_q))
            llbit_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'b0000;
            sc_q    <= 1'b0;
            llbit_q <= 1'b0;
        end else begin
            llbit_q <= llbit_d;
            if (start) begin
                size_q  <= size_d;
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                wstrb_q <= wstrb_d;
                sc_q    <= is_sc;
            end
            case (state_q)
                IDLE:
                    if (start)
                        state_q <= REQ;
                REQ:
                    // Once the address is taken the write will land; a flush
                    // then only suppresses the completion.
                    if (aok)
                        state_q <= dok ? IDLE : (flush_i ? DRAIN : WAIT);
                    else if (flush_i)
                        state_q <= IDLE;
                WAIT:
                    if (dok)
                        state_q <= IDLE;
                    else if (flush_i)
                        state_q <= DRAIN;
                default:
                    if (dok)
                        state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_req_o   = !rst && (state_q == REQ);
    assign bus.data_wr_o    = !rst && (state_q == REQ);
    assign bus.data_size_o  = size_q;
    assign bus.data_addr_o  = addr_q;
    assign bus.data_wdata_o = wdata_q;
    assign bus.data_wstrb_o = wstrb_q;

    assign done_o      = bus_done || sc_fail;
    assign sc_result_o = bus_done && sc_q;
    assign stall_o     = !rst && ((state_q == IDLE) ? start : !bus_done);
    assign ades_o      = op_ok && mis;
    assign badvaddr_o  = (op_ok && mis) ? mem_addr_i : 32'h0;
    assign llbit_o     = llbit_q;
endmodule

// File: tb/tb_mem_store_ctrl.sv
// Self-checking bench for mem_store_ctrl: vector table plus corner-case sequences.
// Bus expectations go through a scoreboard queue popped when data_req_o appears.
module tb_mem_store_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  store_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic        ll_i;
    logic        clr_llbit_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic        sc_result_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;
    logic        llbit_o;

    int checks = 0;
    int errors = 0;

    mem_store_ctrl_if bus ();

    mem_store_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .store_op_i  (store_op_i),
        .mem_addr_i  (mem_addr_i),
        .reg2_i      (reg2_i),
        .ll_i        (ll_i),
        .clr_llbit_i (clr_llbit_i),
        .flush_i     (flush_i),
        .bus         (bus.master),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .sc_result_o (sc_result_o),
        .ades_o      (ades_o),
        .badvaddr_o  (badvaddr_o),
        .llbit_o     (llbit_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        sc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        exp_t        e;
    } vec_t;

    exp_t sbq[$];
    exp_t cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_i = 0; store_op_i = 0; mem_addr_i = 0; reg2_i = 0;
        ll_i = 0; clr_llbit_i = 0; flush_i = 0;
        bus.data_addr_ok_i = 0; bus.data_data_ok_i = 0;
    endtask

    // Present an op for one cycle, push its bus expectation, return at T+1 negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] r, input exp_t e);
        @(negedge clk);
        valid_i = 1; store_op_i = op; mem_addr_i = a; reg2_i = r;
        #1;
        chk("accept_stall", stall_o, 1);
        chk("accept_ades", ades_o, 0);
        chk("accept_done", done_o, 0);
        sbq.push_back(e);
        @(negedge clk);
        valid_i = 0; store_op_i = 0;
    endtask

    // Bounded wait for the request, then pop and compare the bus fields.
    task automatic take_req();
        int n = 0;
        while (!bus.data_req_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", bus.data_req_o, 1);
        if (sbq.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            cur = sbq.pop_front();
            chk("size", bus.data_size_o, cur.size);
            chk("addr", bus.data_addr_o, cur.addr);
            chk("wstrb", bus.data_wstrb_o, cur.strb);
            chk("wdata", bus.data_wdata_o, cur.wdata);
            chk("wr", bus.data_wr_o, 1);
        end
    endtask

    // Minimum-latency store: both oks in the first request cycle.
    task automatic run_fast(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] r, input exp_t e);
        issue(op, a, r, e);
        chk("req_at_T1", bus.data_req_o, 1);
        take_req();
        bus.data_addr_ok_i = 1; bus.data_data_ok_i = 1;
        #1;
        chk("done_T1", done_o, 1);
        chk("stall_done", stall_o, 0);
        chk("sc_result", sc_result_o, e.sc);
        @(negedge clk);
        bus.data_addr_ok_i = 0; bus.data_data_ok_i = 0;
        #1;
        chk("idle_req", bus.data_req_o, 0);
        chk("idle_done", done_o, 0);
    endtask

    vec_t vt[13];

    initial begin
        vt[0]  = '{3'd1, 32'h1003, 32'h11223344, '{2'd0, 32'h1003, 4'b1000, 32'h44444444, 1'b0}};
        vt[1]  = '{3'd1, 32'h1000, 32'h11223344, '{2'd0, 32'h1000, 4'b0001, 32'h44444444, 1'b0}};
        vt[2]  = '{3'd2, 32'h1002, 32'h11223344, '{2'd1, 32'h1002, 4'b1100, 32'h33443344, 1'b0}};
        vt[3]  = '{3'd2, 32'h1000, 32'h11223344, '{2'd1, 32'h1000, 4'b0011, 32'h33443344, 1'b0}};
        vt[4]  = '{3'd3, 32'h1004, 32'h11223344, '{2'd2, 32'h1004, 4'b1111, 32'h11223344, 1'b0}};
        vt[5]  = '{3'd5, 32'h2002, 32'hAABBCCDD, '{2'd2, 32'h2000, 4'b1100, 32'hCCDD0000, 1'b0}};
        vt[6]  = '{3'd4, 32'h2001, 32'hAABBCCDD, '{2'd2, 32'h2000, 4'b0011, 32'h0000AABB, 1'b0}};
        vt[7]  = '{3'd4, 32'h2003, 32'hAABBCCDD, '{2'd2, 32'h2000, 4'b1111, 32'hAABBCCDD, 1'b0}};
        vt[8]  = '{3'd4, 32'h2000, 32'hAABBCCDD, '{2'd2, 32'h2000, 4'b0001, 32'h000000AA, 1'b0}};
        vt[9]  = '{3'd4, 32'h2002, 32'hAABBCCDD, '{2'd2, 32'h2000, 4'b0111, 32'h00AABBCC, 1'b0}};
        vt[10] = '{3'd5, 32'h2001, 32'hAABBCCDD, '{2'd2, 32'h2000, 4'b1110, 32'hBBCCDD00, 1'b0}};
        vt[11] = '{3'd5, 32'h2003, 32'hAABBCCDD, '{2'd2, 32'h2000, 4'b1000, 32'hDD000000, 1'b0}};
        vt[12] = '{3'd5, 32'h2000, 32'hAABBCCDD, '{2'd2, 32'h2000, 4'b1111, 32'hAABBCCDD, 1'b0}};

        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", bus.data_req_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_llbit", llbit_o, 0);
        rst = 0;
        @(negedge clk);
        #1;
        chk("post_rst_size", bus.data_size_o, 0);
        chk("post_rst_addr", bus.data_addr_o, 0);
        chk("post_rst_wstrb", bus.data_wstrb_o, 0);

        for (int i = 0; i < 13; i++)
            run_fast(vt[i].op, vt[i].addr, vt[i].reg2, vt[i].e);

        // Misaligned SW: error flagged, no bus activity.
        @(negedge clk);
        valid_i = 1; store_op_i = 3'd3; mem_addr_i = 32'h3002; reg2_i = 32'h1;
        #1;
        chk("ades_sw", ades_o, 1);
        chk("badvaddr_sw", badvaddr_o, 32'h3002);
        chk("ades_stall", stall_o, 0);
        chk("ades_req", bus.data_req_o, 0);
        @(negedge clk);
        valid_i = 0; store_op_i = 0;
        #1;
        chk("ades_no_req", bus.data_req_o, 0);
        chk("ades_clear", ades_o, 0);

        // Misaligned SH.
        @(negedge clk);
        valid_i = 1; store_op_i = 3'd2; mem_addr_i = 32'h1001;
        #1;
        chk("ades_sh", ades_o, 1);
        chk("badvaddr_sh", badvaddr_o, 32'h1001);
        @(negedge clk);
        valid_i = 0; store_op_i = 0;

        // Op 7 is a no-op.
        @(negedge clk);
        valid_i = 1; store_op_i = 3'd7; mem_addr_i = 32'h1000;
        #1;
        chk("op7_stall", stall_o, 0);
        @(negedge clk);
        valid_i = 0; store_op_i = 0;
        #1;
        chk("op7_req", bus.data_req_o, 0);

        // LL then successful SC, then failing SC.
        @(negedge clk);
        ll_i = 1;
        @(negedge clk);
        ll_i = 0;
        #1;
        chk("ll_set", llbit_o, 1);
        run_fast(3'd6, 32'h4000, 32'h55667788,
                 '{2'd2, 32'h4000, 4'b1111, 32'h55667788, 1'b1});
        chk("sc_clears_ll", llbit_o, 0);
        @(negedge clk);
        valid_i = 1; store_op_i = 3'd6; mem_addr_i = 32'h4000;
        #1;
        chk("scfail_done", done_o, 1);
        chk("scfail_result", sc_result_o, 0);
        chk("scfail_stall", stall_o, 0);
        @(negedge clk);
        valid_i = 0; store_op_i = 0;
        #1;
        chk("scfail_no_req", bus.data_req_o, 0);

        // Clear wins over set.
        @(negedge clk);
        ll_i = 1; clr_llbit_i = 1;
        @(negedge clk);
        ll_i = 0; clr_llbit_i = 0;
        #1;
        chk("clr_wins", llbit_o, 0);

        // Delayed addr_ok, then flush in WAIT -> DRAIN.
        issue(3'd3, 32'h5000, 32'hDEADBEEF,
              '{2'd2, 32'h5000, 4'b1111, 32'hDEADBEEF, 1'b0});
        take_req();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_req", bus.data_req_o, 1);
            chk("hold_addr", bus.data_addr_o, 32'h5000);
            chk("hold_wdata", bus.data_wdata_o, 32'hDEADBEEF);
            chk("hold_stall", stall_o, 1);
            @(negedge clk);
        end
        bus.data_addr_ok_i = 1;
        #1;
        chk("aok_only_done", done_o, 0);
        chk("aok_only_stall", stall_o, 1);
        @(negedge clk);
        bus.data_addr_ok_i = 0;
        #1;
        chk("wait_req", bus.data_req_o, 0);
        chk("wait_stall", stall_o, 1);
        flush_i = 1;
        #1;
        chk("flush_done", done_o, 0);
        @(negedge clk);
        flush_i = 0;
        bus.data_data_ok_i = 1;
        #1;
        chk("drain_done", done_o, 0);
        chk("drain_stall", stall_o, 1);
        @(negedge clk);
        bus.data_data_ok_i = 0;
        #1;
        chk("drain_idle_stall", stall_o, 0);
        chk("drain_idle_req", bus.data_req_o, 0);

        // SH completing in WAIT.
        issue(3'd2, 32'h6002, 32'h0000BEEF,
              '{2'd1, 32'h6002, 4'b1100, 32'hBEEFBEEF, 1'b0});
        take_req();
        bus.data_addr_ok_i = 1;
        @(negedge clk);
        bus.data_addr_ok_i = 0;
        bus.data_data_ok_i = 1;
        #1;
        chk("wait_done", done_o, 1);
        chk("wait_done_stall", stall_o, 0);
        @(negedge clk);
        bus.data_data_ok_i = 0;

        // Reset mid-transaction: no completion.
        issue(3'd3, 32'h7000, 32'h12345678,
              '{2'd2, 32'h7000, 4'b1111, 32'h12345678, 1'b0});
        take_req();
        rst = 1;
        bus.data_addr_ok_i = 1; bus.data_data_ok_i = 1;
        #1;
        chk("rst_mid_done", done_o, 0);
        @(negedge clk);
        rst = 0;
        bus.data_addr_ok_i = 0; bus.data_data_ok_i = 0;
        #1;
        chk("rst_mid_req", bus.data_req_o, 0);
        chk("rst_mid_stall", stall_o, 0);
        chk("rst_mid_addr", bus.data_addr_o, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
